// File: rtl/lfsr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lfsr_pkg : tap-mask constants and the Galois LFSR step function     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package lfsr_pkg;

   localparam int MAX_W = 32;

   localparam logic [4:0] TAPS5_DEF = 5'b11000;
   localparam logic [4:0] TAPS5_MAX = 5'b00100;    // x^5 + x^2 + 1
   localparam logic [7:0] TAPS8_MAX = 8'b01110000; // x^8 + x^6 + x^5 + x^4 + 1

   // Stage 0 always takes the feedback, so the map is a bijection on nonzero states.
   function automatic logic [MAX_W-1:0] next_state(input logic [MAX_W-1:0] q,
                                                   input logic [MAX_W-1:0] taps,
                                                   input int               width);
      logic             msb;
      logic [MAX_W-1:0] r;
      r    = '0;
      msb  = q[width-1];
      r[0] = msb;
      for (int i = 1; i < MAX_W; i++) begin
         if (i < width) begin
            r[i] = q[i-1] ^ (taps[i] & msb);
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_prog_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lfsr_prog_if : control and status bundle of the programmable LFSR  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface lfsr_prog_if #(
   parameter int WIDTH = 5
) ();

   logic             en;
   logic             load;
   logic [WIDTH-1:0] seed;
   logic [WIDTH-1:0] q;
   logic             bit_out;
   logic             wrap;
   logic [WIDTH-1:0] period;
   logic             lockup;

   modport master (
      output en, load, seed,
      input  q, bit_out, wrap, period, lockup
   );

   modport slave (
      input  en, load, seed,
      output q, bit_out, wrap, period, lockup
   );

endinterface
`default_nettype wire

// File: rtl/lfsr_period_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lfsr_period_cnt : start value, step counter, period and wrap pulse |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lfsr_period_cnt #(
   parameter int               WIDTH     = 5,
   parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             restart,
   input  logic [WIDTH-1:0] restart_val,
   input  logic             step,
   input  logic [WIDTH-1:0] next_q,
   output logic             wrap,
   output logic [WIDTH-1:0] period
);

   logic [WIDTH-1:0] start;
   logic [WIDTH-1:0] cnt;

   // A restart abandons the partial count; period keeps the last full measurement.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         start  <= RESET_VAL;
         cnt    <= '0;
         period <= '0;
         wrap   <= 1'b0;
      end else if (restart) begin
         start <= restart_val;
         cnt   <= '0;
         wrap  <= 1'b0;
      end else if (step) begin
         if (next_q == start) begin
            wrap   <= 1'b1;
            period <= cnt + WIDTH'(1);
            cnt    <= '0;
         end else begin
            cnt  <= cnt + WIDTH'(1);
            wrap <= 1'b0;
         end
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/lfsr_prog.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lfsr_prog : parametrised Galois LFSR with seed load and zero guard |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lfsr_prog
   import lfsr_pkg::*;
#(
   parameter int               WIDTH     = 5,
   parameter logic [WIDTH-1:0] TAPS      = WIDTH'(TAPS5_DEF),
   parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
   input  logic        clk,
   input  logic        rst_b,
   lfsr_prog_if.slave  bus
);

   logic [WIDTH-1:0] q_r;
   logic             lockup_r;
   logic [WIDTH-1:0] next_q;
   logic             seed_ok;
   logic             zero_fault;
   logic             restart;
   logic             step;
   logic [WIDTH-1:0] restart_val;

   assign next_q      = WIDTH'(next_state(MAX_W'(q_r), MAX_W'(TAPS), WIDTH));
   assign seed_ok     = bus.load && (bus.seed != '0);
   assign zero_fault  = (q_r == '0);
   // A faulty all-zero state is recovered like a rejected zero seed, independent of en.
   assign restart     = bus.load || zero_fault;
   assign restart_val = seed_ok ? bus.seed : RESET_VAL;
   assign step        = bus.en && !restart;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         q_r      <= RESET_VAL;
         lockup_r <= 1'b0;
      end else if (restart) begin
         q_r      <= restart_val;
         lockup_r <= !seed_ok;
      end else if (step) begin
         q_r <= next_q;
      end
   end

   lfsr_period_cnt #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_period_cnt (
      .clk         (clk),
      .rst_b       (rst_b),
      .restart     (restart),
      .restart_val (restart_val),
      .step        (step),
      .next_q      (next_q),
      .wrap        (bus.wrap),
      .period      (bus.period)
   );

   assign bus.q       = q_r;
   assign bus.bit_out = q_r[WIDTH-1];
   assign bus.lockup  = lockup_r;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_prog.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_lfsr_prog : two LFSR instances checked against a polynomial model|
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_lfsr_prog;
   import lfsr_pkg::*;

   localparam int         W  = 5;
   localparam logic [W-1:0] RV = '1;

   logic clk   = 1'b0;
   logic rst_b = 1'b0;
   always #5 clk = ~clk;

   lfsr_prog_if #(.WIDTH(W)) bus_a ();
   lfsr_prog_if #(.WIDTH(W)) bus_b ();

   lfsr_prog #(.WIDTH(W), .TAPS(TAPS5_DEF), .RESET_VAL(RV)) dut_a (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus_a.slave)
   );

   lfsr_prog #(.WIDTH(W), .TAPS(TAPS5_MAX), .RESET_VAL(RV)) dut_b (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus_b.slave)
   );

   logic         en_i   [2];
   logic         load_i [2];
   logic [W-1:0] seed_i [2];
   logic [W-1:0] q_o    [2];
   logic [W-1:0] per_o  [2];
   logic         wrap_o [2];
   logic         bit_o  [2];
   logic         lock_o [2];

   assign bus_a.en   = en_i[0];
   assign bus_a.load = load_i[0];
   assign bus_a.seed = seed_i[0];
   assign bus_b.en   = en_i[1];
   assign bus_b.load = load_i[1];
   assign bus_b.seed = seed_i[1];
   assign q_o[0] = bus_a.q;  assign per_o[0] = bus_a.period; assign wrap_o[0] = bus_a.wrap;
   assign bit_o[0] = bus_a.bit_out; assign lock_o[0] = bus_a.lockup;
   assign q_o[1] = bus_b.q;  assign per_o[1] = bus_b.period; assign wrap_o[1] = bus_b.wrap;
   assign bit_o[1] = bus_b.bit_out; assign lock_o[1] = bus_b.lockup;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Polynomial view: multiply by x, reduce by the tap polynomial when the top bit falls out.
   function automatic logic [W-1:0] nxt(input logic [W-1:0] q, input logic [W-1:0] taps);
      return (q << 1) ^ (q[W-1] ? (taps | W'(1)) : W'(0));
   endfunction

   logic [W-1:0] taps_m [2];
   logic [W-1:0] m_q    [2];
   logic [W-1:0] m_start[2];
   logic [W-1:0] m_per  [2];
   int           m_steps[2];
   logic         m_wrap [2];
   logic         m_lock [2];

   initial begin
      taps_m[0] = TAPS5_DEF;
      taps_m[1] = TAPS5_MAX;
   end

   always @(posedge clk or negedge rst_b) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_b) begin
            m_q[i] <= RV; m_start[i] <= RV; m_per[i] <= '0;
            m_steps[i] <= 0; m_wrap[i] <= 1'b0; m_lock[i] <= 1'b0;
         end else if (load_i[i] || m_q[i] == '0) begin
            m_q[i]     <= (load_i[i] && seed_i[i] != '0) ? seed_i[i] : RV;
            m_start[i] <= (load_i[i] && seed_i[i] != '0) ? seed_i[i] : RV;
            m_lock[i]  <= !(load_i[i] && seed_i[i] != '0);
            m_steps[i] <= 0;
            m_wrap[i]  <= 1'b0;
         end else if (en_i[i]) begin
            m_q[i] <= nxt(m_q[i], taps_m[i]);
            if (nxt(m_q[i], taps_m[i]) == m_start[i]) begin
               m_wrap[i]  <= 1'b1;
               m_per[i]   <= W'(m_steps[i] + 1);
               m_steps[i] <= 0;
            end else begin
               m_wrap[i]  <= 1'b0;
               m_steps[i] <= m_steps[i] + 1;
            end
         end else begin
            m_wrap[i] <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         check($sformatf("q[%0d]", i),       32'(q_o[i]),    32'(m_q[i]));
         check($sformatf("bit_out[%0d]", i), 32'(bit_o[i]),  32'(m_q[i][W-1]));
         check($sformatf("wrap[%0d]", i),    32'(wrap_o[i]), 32'(m_wrap[i]));
         check($sformatf("period[%0d]", i),  32'(per_o[i]),  32'(m_per[i]));
         check($sformatf("lockup[%0d]", i),  32'(lock_o[i]), 32'(m_lock[i]));
      end
   end

   logic [W-1:0] seq [15];
   logic [31:0]  visited;
   int           steps;
   logic         seen_wrap;

   initial begin
      seq = '{5'h1F, 5'h07, 5'h0E, 5'h1C, 5'h01, 5'h02, 5'h04, 5'h08,
              5'h10, 5'h19, 5'h0B, 5'h16, 5'h15, 5'h13, 5'h1F};
      for (int i = 0; i < 2; i++) begin
         en_i[i] = 1'b0; load_i[i] = 1'b0; seed_i[i] = '0;
      end
      repeat (3) @(negedge clk);
      check("rst_q",      32'(q_o[0]),    32'h1F);
      check("rst_period", 32'(per_o[0]),  32'h0);
      check("rst_lockup", 32'(lock_o[0]), 32'h0);
      check("rst_wrap",   32'(wrap_o[0]), 32'h0);

      // Free run: A through its 14-step cycle, B through all 31 nonzero states.
      rst_b   = 1'b1;
      en_i[0] = 1'b1;
      en_i[1] = 1'b1;
      visited = '0;
      for (int k = 1; k <= 31; k++) begin
         @(negedge clk);
         if (k <= 14) check($sformatf("seq_a[%0d]", k), 32'(q_o[0]), 32'(seq[k]));
         if (k == 14) begin
            check("wrap_a_14",   32'(wrap_o[0]), 32'h1);
            check("period_a_14", 32'(per_o[0]),  32'd14);
         end
         check("b_unique", 32'(visited[q_o[1]]), 32'h0);
         visited[q_o[1]] = 1'b1;
         if (k == 31) begin
            check("wrap_b_31",   32'(wrap_o[1]), 32'h1);
            check("period_b_31", 32'(per_o[1]),  32'd31);
         end
      end
      check("b_all_states", visited, 32'hFFFF_FFFE);
      en_i[0] = 1'b0;
      en_i[1] = 1'b0;

      // Zero seed is rejected, then a nonzero load clears lockup.
      load_i[0] = 1'b1; seed_i[0] = 5'h00;
      @(negedge clk);
      check("zero_q",      32'(q_o[0]),    32'h1F);
      check("zero_lockup", 32'(lock_o[0]), 32'h1);
      seed_i[0] = 5'h01;
      @(negedge clk);
      load_i[0] = 1'b0;
      check("seed1_q",      32'(q_o[0]),    32'h01);
      check("seed1_lockup", 32'(lock_o[0]), 32'h0);

      // Gappy enable: period counts steps, not cycles.
      steps = 0; seen_wrap = 1'b0;
      for (int c = 0; c < 200 && !seen_wrap; c++) begin
         en_i[0] = 1'($urandom_range(0, 1));
         if (en_i[0]) steps++;
         @(negedge clk);
         seen_wrap = wrap_o[0];
      end
      en_i[0] = 1'b0;
      check("gappy_wrap_seen", 32'(seen_wrap),  32'h1);
      check("gappy_steps",     32'(steps),      32'd14);
      check("gappy_period",    32'(per_o[0]),   32'd14);

      // Load lands on the cycle the returning step would occur.
      load_i[0] = 1'b1; seed_i[0] = 5'h1F;
      @(negedge clk);
      load_i[0] = 1'b0; en_i[0] = 1'b1;
      repeat (13) @(negedge clk);
      check("pre_collide_q", 32'(q_o[0]), 32'h13);
      load_i[0] = 1'b1; seed_i[0] = 5'h0B;
      @(negedge clk);
      load_i[0] = 1'b0; en_i[0] = 1'b0;
      check("collide_q",      32'(q_o[0]),   32'h0B);
      check("collide_wrap",   32'(wrap_o[0]), 32'h0);
      check("collide_period", 32'(per_o[0]),  32'd14);

      // Async reset mid-sequence, with lockup set beforehand.
      load_i[0] = 1'b1; seed_i[0] = 5'h00;
      @(negedge clk);
      load_i[0] = 1'b0; en_i[0] = 1'b1;
      repeat (5) @(negedge clk);
      #2 rst_b = 1'b0;
      #1;
      check("arst_q",      32'(q_o[0]),    32'h1F);
      check("arst_period", 32'(per_o[0]),  32'h0);
      check("arst_lockup", 32'(lock_o[0]), 32'h0);
      check("arst_wrap",   32'(wrap_o[0]), 32'h0);
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      check("arst_restart", 32'(q_o[0]), 32'h07);

      // Random mix of enable, load and zero seeds on both instances.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 2; i++) begin
            en_i[i]   = 1'($urandom_range(0, 3) != 0);
            load_i[i] = ($urandom_range(0, 15) == 0);
            seed_i[i] = ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom);
         end
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
